// File: rtl/clk_div_gen_if.sv
// Configuration port of clk_div_gen: a valid/ready write of one channel's divisor and high time.
interface clk_div_gen_if #(
   parameter int CH    = 2,
   parameter int DIV_W = 16
);
   localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic [DIV_W-1:0] cfg_high;

   modport master (output cfg_valid, cfg_ch, cfg_div, cfg_high, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_high, output cfg_ready);
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with glitch-free runtime reconfiguration and a lock flag.
// Define PHASE_ALIGN_EN to add the sync_req input that restarts every channel's period on the same edge.
module clk_div_gen #(
   parameter int CH          = 2,
   parameter int DIV_W       = 16,
   parameter int DEF_DIV     = 2,
   parameter int DEF_HIGH    = 1,
   parameter int LOCK_CYCLES = 16
) (
   input  logic          clkin,
   input  logic          rst_n,
   clk_div_gen_if.slave  cfg,
`ifdef PHASE_ALIGN_EN
   input  logic          sync_req,
`endif
   output logic [CH-1:0] clkout,
   output logic [CH-1:0] tick,
   output logic          lock
);

   localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;
   localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

   typedef enum logic [1:0] {UNLOCKED, SETTLE, LOCKED} lockState_e;

   logic [DIV_W-1:0] div_q   [CH];
   logic [DIV_W-1:0] div_d   [CH];
   logic [DIV_W-1:0] high_q  [CH];
   logic [DIV_W-1:0] high_d  [CH];
   logic [DIV_W-1:0] cnt_q   [CH];
   logic [DIV_W-1:0] cnt_d   [CH];
   logic [DIV_W-1:0] sdiv_q  [CH];
   logic [DIV_W-1:0] sdiv_d  [CH];
   logic [DIV_W-1:0] shigh_q [CH];
   logic [DIV_W-1:0] shigh_d [CH];
   logic [CH-1:0]    pending_q, pending_d;
   logic [CH-1:0]    clkout_q, clkout_d;
   logic [CH-1:0]    tick_q, tick_d;
   lockState_e       state_q, state_d;
   logic [LC_W-1:0]  lcnt_q, lcnt_d;
   logic             lock_q;
   logic             cfgReady, cfgAccept, lockEvent, syncNow;
   logic [CH-1:0]    cfgSel, wrapEdge, applyNow;

`ifdef PHASE_ALIGN_EN
   assign syncNow = sync_req;
`else
   assign syncNow = 1'b0;
`endif

   // Out-of-range channel codes leave cfgSel empty: always ready, accepted and dropped.
   always_comb begin
      cfgSel   = '0;
      cfgReady = 1'b1;
      for (int i = 0; i < CH; i++) begin
         if (cfg.cfg_ch == CH_W'(i)) begin
            cfgSel[i] = 1'b1;
            cfgReady  = ~pending_q[i];
         end
      end
   end

   assign cfg.cfg_ready = cfgReady;
   assign cfgAccept     = cfg.cfg_valid & cfgReady & (|cfgSel);

   // A shadow is only applied at a period boundary; a disabled channel is at a boundary every edge.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         wrapEdge[i]  = syncNow || (div_q[i] < TWO) || (cnt_q[i] == div_q[i] - ONE);
         applyNow[i]  = pending_q[i] & wrapEdge[i];
         div_d[i]     = applyNow[i] ? sdiv_q[i] : div_q[i];
         high_d[i]    = applyNow[i] ? shigh_q[i] : high_q[i];
         cnt_d[i]     = (wrapEdge[i] || (div_d[i] < TWO)) ? '0 : cnt_q[i] + ONE;
         clkout_d[i]  = (div_d[i] >= TWO) && (cnt_d[i] < high_d[i]);
         tick_d[i]    = (div_d[i] >= TWO) && (cnt_d[i] == '0);
         sdiv_d[i]    = sdiv_q[i];
         shigh_d[i]   = shigh_q[i];
         pending_d[i] = pending_q[i] & ~applyNow[i];
         if (cfgAccept && cfgSel[i]) begin
            sdiv_d[i]    = cfg.cfg_div;
            shigh_d[i]   = cfg.cfg_high;
            pending_d[i] = 1'b1;
         end
      end
   end

   always_comb begin
      lockEvent = cfgAccept | (|pending_q) | syncNow;
      state_d   = state_q;
      lcnt_d    = lcnt_q;
      case (state_q)
         UNLOCKED: begin
            lcnt_d = '0;
            if (pending_q == '0 && !syncNow) state_d = SETTLE;
         end
         SETTLE: begin
            if (lockEvent) begin
               state_d = UNLOCKED;
               lcnt_d  = '0;
            end else if (lcnt_q == LC_W'(LOCK_CYCLES - 1)) begin
               state_d = LOCKED;
               lcnt_d  = '0;
            end else begin
               lcnt_d = lcnt_q + LC_W'(1);
            end
         end
         LOCKED: begin
            if (lockEvent) begin
               state_d = UNLOCKED;
               lcnt_d  = '0;
            end
         end
         default: begin
            state_d = UNLOCKED;
            lcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            div_q[i]   <= DIV_W'(DEF_DIV);
            high_q[i]  <= DIV_W'(DEF_HIGH);
            cnt_q[i]   <= DIV_W'(DEF_DIV - 1);
            sdiv_q[i]  <= DIV_W'(DEF_DIV);
            shigh_q[i] <= DIV_W'(DEF_HIGH);
         end
         pending_q <= '0;
         clkout_q  <= '0;
         tick_q    <= '0;
         state_q   <= UNLOCKED;
         lcnt_q    <= '0;
         lock_q    <= 1'b0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            div_q[i]   <= div_d[i];
            high_q[i]  <= high_d[i];
            cnt_q[i]   <= cnt_d[i];
            sdiv_q[i]  <= sdiv_d[i];
            shigh_q[i] <= shigh_d[i];
         end
         pending_q <= pending_d;
         clkout_q  <= clkout_d;
         tick_q    <= tick_d;
         state_q   <= state_d;
         lcnt_q    <= lcnt_d;
         lock_q    <= (state_d == LOCKED);
      end
   end

   assign clkout = clkout_q;
   assign tick   = tick_q;
   assign lock   = lock_q;

endmodule
